// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between byte-stream requesters, the round-robin arbiter and the
// UART transmitter core; master is the environment side, slave is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic               uart_tx_start;
  logic [7:0]         uart_tx_data;
  logic               uart_tx_busy;
  logic [N_REQ-1:0]   grant;
  logic               locked;
  logic               timeout;
  logic               abort;

  modport master (
    output req_valid, req_data, req_last, uart_tx_busy,
    input  req_ready, uart_tx_start, uart_tx_data, grant, locked, timeout, abort
  );

  modport slave (
    input  req_valid, req_data, req_last, uart_tx_busy,
    output req_ready, uart_tx_start, uart_tx_data, grant, locked, timeout, abort
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one UART transmitter among N_REQ byte streams,
// with packet locking on req_last, busy-rise timeout and idle-gap lock release.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 4,
  parameter int GAP_MAX      = 255
) (
  input logic              i_clk,
  input logic              i_rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HI,
    WAIT_LO
  } state_t;

  state_t           r_state, w_stateNext;
  logic [PW-1:0]    r_ptr, w_ptrNext;
  logic [3:0]       r_busyCnt, w_busyCntNext;
  logic [7:0]       r_gapCnt, w_gapCntNext;
  logic [N_REQ-1:0] r_ready, w_readyNext;
  logic [N_REQ-1:0] r_grant, w_grantNext;
  logic             r_start, w_startNext;
  logic [7:0]       r_data, w_dataNext;
  logic             r_locked, w_lockedNext;
  logic             r_timeout, w_timeoutNext;
  logic             r_abort, w_abortNext;

  logic [N_REQ-1:0] w_eligible;
  logic             w_ownerValid;
  logic             w_found;
  logic [PW-1:0]    w_winIdx;
  logic [N_REQ-1:0] w_winOnehot;
  logic [7:0]       w_winData;
  logic             w_winLast;
  int               w_dist;
  int               w_bestDist;

  assign w_ownerValid = |(bus.req_valid & r_grant);
  assign w_eligible   = r_locked ? (bus.req_valid & r_grant) : bus.req_valid;
  assign w_winOnehot  = N_REQ'(1) << w_winIdx;

  // Circular priority: the index just after the pointer has distance 0.
  always_comb begin
    w_found    = 1'b0;
    w_winIdx   = '0;
    w_bestDist = N_REQ;
    w_dist     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_dist = (i + N_REQ - 1 - int'(r_ptr)) % N_REQ;
      if (w_eligible[i] && (w_dist < w_bestDist)) begin
        w_found    = 1'b1;
        w_bestDist = w_dist;
        w_winIdx   = PW'(i);
      end
    end
  end

  always_comb begin
    w_winData = '0;
    w_winLast = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_winIdx == PW'(i)) begin
        w_winData = bus.req_data[8*i +: 8];
        w_winLast = bus.req_last[i];
      end
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_ptrNext     = r_ptr;
    w_busyCntNext = r_busyCnt;
    w_gapCntNext  = r_gapCnt;
    w_readyNext   = '0;
    w_startNext   = 1'b0;
    w_timeoutNext = 1'b0;
    w_abortNext   = 1'b0;
    w_grantNext   = r_grant;
    w_dataNext    = r_data;
    w_lockedNext  = r_locked;

    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_dataNext    = w_winData;
          w_startNext   = 1'b1;
          w_readyNext   = w_winOnehot;
          w_grantNext   = w_winOnehot;
          w_ptrNext     = w_winIdx;
          w_lockedNext  = ~w_winLast;
          w_gapCntNext  = '0;
          w_busyCntNext = '0;
          w_stateNext   = WAIT_HI;
        end else if (r_locked && !w_ownerValid) begin
          // A stalled owner only holds the transmitter for GAP_MAX idle cycles.
          if (r_gapCnt == 8'(GAP_MAX - 1)) begin
            w_lockedNext = 1'b0;
            w_abortNext  = 1'b1;
            w_gapCntNext = '0;
          end else begin
            w_gapCntNext = r_gapCnt + 8'd1;
          end
        end
      end

      WAIT_HI: begin
        if (bus.uart_tx_busy) begin
          w_busyCntNext = '0;
          w_stateNext   = WAIT_LO;
        end else if (r_busyCnt == 4'(BUSY_TIMEOUT - 1)) begin
          w_busyCntNext = '0;
          w_timeoutNext = 1'b1;
          w_stateNext   = IDLE;
        end else begin
          w_busyCntNext = r_busyCnt + 4'd1;
        end
      end

      WAIT_LO: begin
        if (!bus.uart_tx_busy) begin
          w_stateNext = IDLE;
        end
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_ptr     <= PW'(N_REQ - 1);
      r_busyCnt <= '0;
      r_gapCnt  <= '0;
      r_ready   <= '0;
      r_grant   <= '0;
      r_start   <= 1'b0;
      r_data    <= '0;
      r_locked  <= 1'b0;
      r_timeout <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_ptr     <= w_ptrNext;
      r_busyCnt <= w_busyCntNext;
      r_gapCnt  <= w_gapCntNext;
      r_ready   <= w_readyNext;
      r_grant   <= w_grantNext;
      r_start   <= w_startNext;
      r_data    <= w_dataNext;
      r_locked  <= w_lockedNext;
      r_timeout <= w_timeoutNext;
      r_abort   <= w_abortNext;
    end
  end

  assign bus.req_ready     = r_ready;
  assign bus.uart_tx_start = r_start;
  assign bus.uart_tx_data  = r_data;
  assign bus.grant         = r_grant;
  assign bus.locked        = r_locked;
  assign bus.timeout       = r_timeout;
  assign bus.abort         = r_abort;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random packets, checked
// against a queue-based round-robin model and a simple UART busy model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int BT  = 4;
  localparam int GAP = 255;
  localparam int DW  = 8 * N;

  typedef logic [1:0] idx_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(
    .N_REQ(N),
    .BUSY_TIMEOUT(BT),
    .GAP_MAX(GAP)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [8:0] reqQ [N][$];
  int   winLog[$];
  int   mPtr, mOwner;
  logic mLocked;
  int   busyLeft, fixedLen, lastLen;
  logic neverBusy;
  int   spacingOn, lastStart;
  int   timeoutCount, abortCount, lastTimeout, lastAbort;
  logic prevStart;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic last, input logic [7:0] d);
    reqQ[idx_t'(r)].push_back({last, d});
  endtask

  function automatic int pendingCount();
    int n;
    n = 0;
    for (int i = 0; i < N; i++) n += reqQ[idx_t'(i)].size();
    return n;
  endfunction

  function automatic int onehotToIdx(input logic [N-1:0] oh);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (oh == (N'(1) << i)) r = i;
    return r;
  endfunction

  // Reference rule: locked -> owner only; else first non-empty queue after the pointer.
  function automatic int modelWinner();
    int j;
    if (mLocked) return (reqQ[idx_t'(mOwner)].size() > 0) ? mOwner : -1;
    for (int k = 1; k <= N; k++) begin
      j = (mPtr + k) % N;
      if (reqQ[idx_t'(j)].size() > 0) return j;
    end
    return -1;
  endfunction

  task automatic applyStimulus();
    logic [N-1:0]  v;
    logic [N-1:0]  l;
    logic [DW-1:0] d;
    logic [8:0]    h;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < N; i++) begin
      if (reqQ[idx_t'(i)].size() > 0) begin
        h = reqQ[idx_t'(i)][0];
        v = v | (N'(1) << i);
        l = l | (N'(h[8]) << i);
        d = d | (DW'(h[7:0]) << (8 * i));
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
  endtask

  task automatic tick();
    int snap;
    logic [8:0] head;
    snap = modelWinner();
    applyStimulus();
    @(posedge clk);
    #1;
    cycle++;
    if (rst) begin
      busyLeft  = 0;
      mPtr      = N - 1;
      mLocked   = 1'b0;
      mOwner    = 0;
      lastStart = -1;
    end
    if (bus.uart_tx_start) begin
      checkOutput("startPulseWidth", 32'(prevStart), 0);
      if (snap < 0) begin
        checkOutput("unexpectedStart", 32'(bus.uart_tx_start), 0);
      end else begin
        head = reqQ[idx_t'(snap)][0];
        checkOutput("grant", 32'(bus.grant), 1 << snap);
        checkOutput("ready", 32'(bus.req_ready), 1 << snap);
        checkOutput("data", 32'(bus.uart_tx_data), 32'(head[7:0]));
        checkOutput("locked", 32'(bus.locked), 32'(!head[8]));
        if (spacingOn != 0 && lastStart >= 0) checkOutput("spacing", cycle - lastStart, lastLen + 2);
        void'(reqQ[idx_t'(snap)].pop_front());
        mPtr    = snap;
        mOwner  = snap;
        mLocked = !head[8];
      end
      winLog.push_back(onehotToIdx(bus.grant));
      lastStart = cycle;
      busyLeft  = neverBusy ? 0 : ((fixedLen > 0) ? fixedLen : $urandom_range(1, 6));
      lastLen   = busyLeft;
    end else begin
      if (bus.req_ready != '0) checkOutput("readyWithoutStart", 32'(bus.req_ready), 0);
      if (busyLeft > 0) busyLeft--;
    end
    prevStart = bus.uart_tx_start;
    if (bus.timeout) begin
      timeoutCount++;
      lastTimeout = cycle;
    end
    if (bus.abort) begin
      abortCount++;
      lastAbort = cycle;
      mLocked   = 1'b0;
    end
    bus.uart_tx_busy = (busyLeft > 0);
  endtask

  task automatic runUntilDrained(input int bound, input string tag);
    int n;
    n = 0;
    while (pendingCount() > 0 && n < bound) begin
      tick();
      n++;
    end
    checkOutput(tag, pendingCount(), 0);
    repeat (12) tick();
    lastStart = -1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "Ready"}, 32'(bus.req_ready), 0);
    checkOutput({tag, "Start"}, 32'(bus.uart_tx_start), 0);
    checkOutput({tag, "Data"}, 32'(bus.uart_tx_data), 0);
    checkOutput({tag, "Grant"}, 32'(bus.grant), 0);
    checkOutput({tag, "Locked"}, 32'(bus.locked), 0);
    checkOutput({tag, "Timeout"}, 32'(bus.timeout), 0);
    checkOutput({tag, "Abort"}, 32'(bus.abort), 0);
  endtask

  initial begin
    int s;
    int base;
    int n;
    int nPkt;
    int len;

    bus.req_valid    = '0;
    bus.req_data     = '0;
    bus.req_last     = '0;
    bus.uart_tx_busy = 1'b0;
    mPtr = N - 1; mOwner = 0; mLocked = 1'b0;
    busyLeft = 0; fixedLen = 0; lastLen = 0; neverBusy = 1'b0;
    spacingOn = 1; lastStart = -1; prevStart = 1'b0;
    timeoutCount = 0; abortCount = 0; lastTimeout = -1000; lastAbort = -1000;

    rst = 1'b1;
    tick();
    tick();
    checkResetState("reset");
    rst = 1'b0;

    $display("[TB] single byte from requester 0");
    fixedLen = 5;
    push(0, 1'b1, 8'h55);
    push(0, 1'b1, 8'h56);
    tick();
    checkOutput("t1Start", 32'(bus.uart_tx_start), 1);
    checkOutput("t1Data", 32'(bus.uart_tx_data), 32'h55);
    checkOutput("t1Grant", 32'(bus.grant), 32'b0001);
    checkOutput("t1Ready", 32'(bus.req_ready), 32'b0001);
    tick();
    tick();
    checkOutput("t1DataHeld", 32'(bus.uart_tx_data), 32'h55);
    checkOutput("t1StartLow", 32'(bus.uart_tx_start), 0);
    runUntilDrained(100, "t1Drain");

    $display("[TB] lock released by idle gap");
    spacingOn = 0;
    fixedLen  = 3;
    push(1, 1'b0, 8'h77);
    tick();
    s = lastStart;
    checkOutput("gapStartCycle", s, cycle);
    checkOutput("gapLocked", 32'(bus.locked), 1);
    push(0, 1'b1, 8'h88);
    runUntilDrained(400, "gapDrain");
    checkOutput("gapAbortCount", abortCount, 1);
    checkOutput("gapAbortCycle", lastAbort - s, 1 + 3 + GAP);
    checkOutput("gapNextWinner", winLog[winLog.size() - 1], 0);

    $display("[TB] locked packet from requester 2");
    spacingOn = 1;
    fixedLen  = 2;
    base = winLog.size();
    push(2, 1'b0, 8'h10);
    push(2, 1'b0, 8'h11);
    push(2, 1'b1, 8'h12);
    tick();
    push(0, 1'b1, 8'hB0);
    push(3, 1'b1, 8'hB3);
    runUntilDrained(200, "pktDrain");
    checkOutput("pktCount", winLog.size() - base, 5);
    if (winLog.size() - base == 5) begin
      checkOutput("pktOrder0", winLog[base],     2);
      checkOutput("pktOrder1", winLog[base + 1], 2);
      checkOutput("pktOrder2", winLog[base + 2], 2);
      checkOutput("pktOrder3", winLog[base + 3], 3);
      checkOutput("pktOrder4", winLog[base + 4], 0);
    end

    $display("[TB] all requesters streaming single bytes");
    fixedLen = 0;
    base = winLog.size();
    for (int r = 0; r < N; r++) begin
      for (int k = 0; k < 3; k++) push(r, 1'b1, 8'hA0 + 8'(r));
    end
    runUntilDrained(500, "rrDrain");
    checkOutput("rrCount", winLog.size() - base, 3 * N);
    if (winLog.size() - base == 3 * N) begin
      checkOutput("rrFirst", winLog[base], 1);
      for (int k = base; k < base + 3 * N - 1; k++) begin
        checkOutput("rrRotation", winLog[k + 1], (winLog[k] + 1) % N);
      end
    end

    $display("[TB] busy never rises");
    spacingOn = 0;
    neverBusy = 1'b1;
    push(1, 1'b1, 8'hC1);
    push(3, 1'b1, 8'hC3);
    tick();
    s = lastStart;
    checkOutput("toFirstStart", s, cycle);
    n = 0;
    while (!bus.timeout && n < 20) begin
      tick();
      n++;
    end
    checkOutput("toTimeoutCycle", lastTimeout - s, BT);
    tick();
    checkOutput("toNextStart", 32'(bus.uart_tx_start), 1);
    checkOutput("toNextSpacing", lastStart - lastTimeout, 1);
    runUntilDrained(100, "toDrain");
    checkOutput("toCount", timeoutCount, 2);
    neverBusy = 1'b0;

    $display("[TB] reset during a locked frame");
    spacingOn = 1;
    fixedLen  = 8;
    push(2, 1'b0, 8'hD0);
    push(2, 1'b1, 8'hD1);
    tick();
    checkOutput("rstLockedBefore", 32'(bus.locked), 1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checkResetState("midReset");
    rst = 1'b0;
    base = winLog.size();
    push(0, 1'b1, 8'hE0);
    push(3, 1'b1, 8'hE3);
    runUntilDrained(200, "rstDrain");
    checkOutput("rstFirstWinner", (winLog.size() > base) ? winLog[base] : -1, 0);

    $display("[TB] random packets");
    fixedLen = 0;
    n = timeoutCount + abortCount;
    for (int r = 0; r < N; r++) begin
      nPkt = $urandom_range(1, 3);
      for (int p = 0; p < nPkt; p++) begin
        len = $urandom_range(1, 3);
        for (int b = 0; b < len; b++) push(r, (b == len - 1), 8'($urandom));
      end
    end
    runUntilDrained(3000, "randDrain");
    checkOutput("randNoTimeoutAbort", timeoutCount + abortCount, n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
